// File: rtl/phase_threshold_trigger.sv
// rtl/phase_threshold_trigger.sv - negative-going pulse trigger with peak search and dead time
// Optional TRIG_EVENT_COUNT_EN adds a saturating trig_count output.
module phase_threshold_trigger #(
   parameter int DATA_W   = 16,
   parameter int TS_W     = 32,
   parameter int MAX_PEAK = 64
) (
   input  logic                     user_clk,
   input  logic                     user_rst,
   input  logic [31:0]              threshold_in,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     trig_valid,
   output logic signed [DATA_W-1:0] trig_peak,
   output logic [TS_W-1:0]          trig_time,
`ifdef TRIG_EVENT_COUNT_EN
   output logic [31:0]              trig_count,
`endif
   output logic                     busy
);

   localparam int PK_W = $clog2(MAX_PEAK + 1);
   localparam logic [PK_W-1:0] PK_MAX = PK_W'(MAX_PEAK);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEAK = 2'd1,
      DEAD = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [11:0]              cfg_dead;
   logic [TS_W-1:0]          ts;
   logic signed [DATA_W-1:0] min_val, min_nxt;
   logic [TS_W-1:0]          min_ts, min_ts_nxt;
   logic [PK_W-1:0]          pk_cnt, pk_nxt, pk_inc;
   logic [11:0]              dcnt, dcnt_nxt;
   logic                     emit;
   logic signed [DATA_W-1:0] emit_peak;
   logic [TS_W-1:0]          emit_time;
   logic                     enable;
   logic signed [DATA_W-1:0] thr_live;
   logic                     unused_cfg_bits;

   // In IDLE the config copy tracks threshold_in, so the live threshold is the copy's value.
   assign enable          = threshold_in[31];
   assign thr_live        = DATA_W'($signed(threshold_in[15:0]));
   assign pk_inc          = pk_cnt + PK_W'(1);
   assign busy            = (state != IDLE);
   assign unused_cfg_bits = &{1'b0, threshold_in[30:28]};

   always_comb begin
      state_nxt  = state;
      min_nxt    = min_val;
      min_ts_nxt = min_ts;
      pk_nxt     = pk_cnt;
      dcnt_nxt   = dcnt;
      emit       = 1'b0;
      emit_peak  = min_val;
      emit_time  = min_ts;
      case (state)
         IDLE: begin
            if (in_valid && (in_data < thr_live)) begin
               state_nxt  = PEAK;
               min_nxt    = in_data;
               min_ts_nxt = ts;
               pk_nxt     = PK_W'(1);
            end
         end
         PEAK: begin
            if (in_valid) begin
               if (in_data > min_val) begin
                  emit = 1'b1;
               end else begin
                  // Ties keep the earlier timestamp.
                  if (in_data < min_val) begin
                     min_nxt    = in_data;
                     min_ts_nxt = ts;
                  end
                  pk_nxt = pk_inc;
                  if (pk_inc == PK_MAX) begin
                     emit      = 1'b1;
                     emit_peak = min_nxt;
                     emit_time = min_ts_nxt;
                  end
               end
            end
         end
         DEAD: begin
            if (in_valid) begin
               if (dcnt <= 12'd1) begin
                  state_nxt = IDLE;
                  dcnt_nxt  = 12'd0;
               end else begin
                  dcnt_nxt = dcnt - 12'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (emit) begin
         dcnt_nxt  = cfg_dead;
         state_nxt = (cfg_dead != 12'd0) ? DEAD : IDLE;
      end
      if (!enable) begin
         state_nxt = IDLE;
         emit      = 1'b0;
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state      <= IDLE;
         cfg_dead   <= 12'd0;
         ts         <= '0;
         min_val    <= '0;
         min_ts     <= '0;
         pk_cnt     <= '0;
         dcnt       <= 12'd0;
         trig_valid <= 1'b0;
         trig_peak  <= '0;
         trig_time  <= '0;
      end else begin
         state   <= state_nxt;
         ts      <= ts + TS_W'(1);
         min_val <= min_nxt;
         min_ts  <= min_ts_nxt;
         pk_cnt  <= pk_nxt;
         dcnt    <= dcnt_nxt;
         if (state == IDLE) begin
            cfg_dead <= threshold_in[27:16];
         end
         trig_valid <= emit;
         if (emit) begin
            trig_peak <= emit_peak;
            trig_time <= emit_time;
         end
      end
   end

`ifdef TRIG_EVENT_COUNT_EN
   always_ff @(posedge user_clk) begin
      if (user_rst || !enable) begin
         trig_count <= 32'd0;
      end else if (emit && (trig_count != 32'hFFFF_FFFF)) begin
         trig_count <= trig_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_phase_threshold_trigger.sv
// tb/tb_phase_threshold_trigger.sv - directed and random checks against a pulse-level reference model
module tb_phase_threshold_trigger;

   localparam int MAXP = 64;
   localparam logic [31:0] T_BASE = 32'h800A_FC18;

   logic               user_clk = 1'b0;
   logic               user_rst;
   logic [31:0]        threshold_in;
   logic               in_valid;
   logic signed [15:0] in_data;
   logic               trig_valid;
   logic signed [15:0] trig_peak;
   logic [31:0]        trig_time;
   logic               busy;
`ifdef TRIG_EVENT_COUNT_EN
   logic [31:0]        trig_count;
`endif

   int vectors     = 0;
   int miscompares = 0;

   always #5 user_clk = ~user_clk;

   phase_threshold_trigger #(.DATA_W(16), .TS_W(32), .MAX_PEAK(MAXP)) dut (
      .user_clk     (user_clk),
      .user_rst     (user_rst),
      .threshold_in (threshold_in),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .trig_valid   (trig_valid),
      .trig_peak    (trig_peak),
      .trig_time    (trig_time),
`ifdef TRIG_EVENT_COUNT_EN
      .trig_count   (trig_count),
`endif
      .busy         (busy)
   );

   // Reference: a pulse is the list of its samples; the event is the first minimum of that list.
   logic signed [15:0] pq[$];
   logic [31:0]        pts[$];
   int                 skip;
   logic [11:0]        cap_dead;
   logic [31:0]        mts;
   logic               exp_v;
   logic signed [15:0] exp_pk;
   logic [31:0]        exp_tm;
   logic [31:0]        exp_cnt;
   logic [31:0]        mark;

   task automatic emit_pulse();
      int bi = 0;
      for (int i = 1; i < pq.size(); i++) if (pq[i] < pq[bi]) bi = i;
      exp_v  = 1'b1;
      exp_pk = pq[bi];
      exp_tm = pts[bi];
      skip   = int'(cap_dead);
      pq.delete();
      pts.delete();
      if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
   endtask

   task automatic model(input logic r, input logic [31:0] t, input logic v, input logic signed [15:0] d);
      logic signed [15:0] cur_min;
      if (r) begin
         pq.delete(); pts.delete();
         skip = 0; mts = 0; exp_v = 0; exp_pk = 0; exp_tm = 0; exp_cnt = 0;
         return;
      end
      exp_v = 1'b0;
      if (!t[31]) begin
         pq.delete(); pts.delete();
         skip = 0; exp_cnt = 0;
      end else if (v) begin
         if (pq.size() > 0) begin
            cur_min = pq[0];
            foreach (pq[i]) if (pq[i] < cur_min) cur_min = pq[i];
            if (d > cur_min) begin
               emit_pulse();
            end else begin
               pq.push_back(d);
               pts.push_back(mts);
               if (pq.size() == MAXP) emit_pulse();
            end
         end else if (skip > 0) begin
            skip--;
         end else if (d < $signed(t[15:0])) begin
            pq.push_back(d);
            pts.push_back(mts);
            cap_dead = t[27:16];
         end
      end
      mts = mts + 1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic [31:0] t, input logic v, input int d);
      logic signed [15:0] ds;
      ds           = 16'(d);
      user_rst     = r;
      threshold_in = t;
      in_valid     = v;
      in_data      = ds;
      @(posedge user_clk);
      #1;
      model(r, t, v, ds);
      chk("trig_valid", {31'b0, trig_valid}, {31'b0, exp_v});
      chk("trig_peak", {16'b0, trig_peak}, {16'b0, exp_pk});
      chk("trig_time", trig_time, exp_tm);
      chk("busy", {31'b0, busy}, {31'b0, (pq.size() > 0) || (skip > 0)});
`ifdef TRIG_EVENT_COUNT_EN
      chk("trig_count", trig_count, exp_cnt);
`endif
   endtask

   initial begin
      logic [31:0] cur_t;
      int          dv;
      // Reset and idle until timestamp 5
      step(1'b1, 32'h0, 1'b0, 0);
      step(1'b1, 32'h0, 1'b0, 0);
      chk("rst_valid", {31'b0, trig_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      for (int i = 0; i < 5; i++) step(1'b0, T_BASE, 1'b0, 0);

      // Basic pulse
      step(1'b0, T_BASE, 1'b1, 0);
      step(1'b0, T_BASE, 1'b1, -500);
      step(1'b0, T_BASE, 1'b1, -1200);
      step(1'b0, T_BASE, 1'b1, -1500);
      step(1'b0, T_BASE, 1'b1, -1400);
      chk("basic_valid", {31'b0, trig_valid}, 32'd1);
      chk("basic_peak", {16'b0, trig_peak}, 32'h0000_FA24);
      chk("basic_time", trig_time, 32'd8);

      // Dead time of 10 samples, 11th retriggers
      for (int i = 0; i < 10; i++) step(1'b0, T_BASE, 1'b1, -2000);
      chk("dead_end_busy", {31'b0, busy}, 32'd0);
      step(1'b0, T_BASE, 1'b1, -2000);
      chk("retrig_busy", {31'b0, busy}, 32'd1);
      step(1'b0, T_BASE, 1'b1, -1900);
      chk("retrig_peak", {16'b0, trig_peak}, 32'h0000_F830);
      for (int i = 0; i < 10; i++) step(1'b0, T_BASE, 1'b1, 0);

      // Threshold equality and tie
      step(1'b0, T_BASE, 1'b1, -1000);
      chk("equal_no_trig", {31'b0, busy}, 32'd0);
      step(1'b0, T_BASE, 1'b1, -1001);
      mark = mts;
      step(1'b0, T_BASE, 1'b1, -1300);
      step(1'b0, T_BASE, 1'b1, -1300);
      step(1'b0, T_BASE, 1'b1, -1200);
      chk("tie_peak", {16'b0, trig_peak}, 32'h0000_FAEC);
      chk("tie_time", trig_time, mark);
      for (int i = 0; i < 10; i++) step(1'b0, T_BASE, 1'b1, 0);

      // Forced emit at the 64th sample
      for (int i = 0; i < 70; i++) begin
         step(1'b0, T_BASE, 1'b1, -1001 - i);
         if (i == 63) begin
            chk("forced_valid", {31'b0, trig_valid}, 32'd1);
            chk("forced_peak", {16'b0, trig_peak}, 32'h0000_FBD8);
         end
      end
      for (int i = 0; i < 10; i++) step(1'b0, T_BASE, 1'b1, 0);

      // Disable mid-peak
      step(1'b0, T_BASE, 1'b1, -1500);
      step(1'b0, T_BASE, 1'b1, -1600);
      step(1'b0, 32'h0000_FC18, 1'b1, -1700);
      chk("disable_valid", {31'b0, trig_valid}, 32'd0);
      chk("disable_busy", {31'b0, busy}, 32'd0);
      for (int i = 0; i < 3; i++) step(1'b0, T_BASE, 1'b1, 0);

      // Config change during DEAD applies only after IDLE
      step(1'b0, T_BASE, 1'b1, -1200);
      step(1'b0, T_BASE, 1'b1, -1100);
      for (int i = 0; i < 10; i++) step(1'b0, 32'h8003_F448, 1'b1, -2000);
      chk("freeze_dead_len", {31'b0, busy}, 32'd0);
      step(1'b0, 32'h8003_F448, 1'b1, -2000);
      chk("new_thr_no_trig", {31'b0, busy}, 32'd0);
      step(1'b0, 32'h8003_F448, 1'b1, -3500);
      chk("new_thr_trig", {31'b0, busy}, 32'd1);
      step(1'b0, 32'h8003_F448, 1'b1, 0);
      for (int i = 0; i < 5; i++) step(1'b0, T_BASE, 1'b1, 0);

      // in_valid gaps inside a pulse
      step(1'b0, T_BASE, 1'b1, -1200);
      step(1'b0, T_BASE, 1'b0, -3000);
      step(1'b0, T_BASE, 1'b0, -3000);
      mark = mts;
      step(1'b0, T_BASE, 1'b1, -1500);
      step(1'b0, T_BASE, 1'b1, -1300);
      chk("gap_time", trig_time, mark);
      for (int i = 0; i < 10; i++) step(1'b0, T_BASE, 1'b1, 0);

      // Reset mid-peak
      step(1'b0, T_BASE, 1'b1, -1200);
      step(1'b0, T_BASE, 1'b1, -1300);
      step(1'b1, T_BASE, 1'b1, -1400);
      chk("rst_mid_valid", {31'b0, trig_valid}, 32'd0);
      chk("rst_mid_peak", {16'b0, trig_peak}, 32'd0);
      chk("rst_mid_time", trig_time, 32'd0);
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);

      // Randomized traffic
      cur_t = T_BASE;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(199, 0) == 0) begin
            cur_t[31]    = ($urandom_range(19, 0) != 0);
            cur_t[30:28] = 3'b0;
            cur_t[27:16] = 12'($urandom_range(15, 0));
            cur_t[15:0]  = 16'(-int'($urandom_range(1500, 800)));
         end
         dv = int'($urandom_range(3000, 0)) - 2500;
         step(($urandom_range(999, 0) == 0), cur_t, ($urandom_range(3, 0) != 0), dv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/phase_threshold_trigger.md
Name: phase_threshold_trigger

Overview:
Per-sample photon trigger that sits directly downstream of the capture threshold software register. It consumes the 32-bit packed threshold word in the user_clk domain and watches a signed phase stream for negative-going pulses. On a threshold crossing it searches for the pulse minimum and emits one event carrying peak value and timestamp. It then enforces a programmable dead time before re-arming.

Parameters:
DATA_W, 16, phase sample width (signed two's complement)
TS_W, 32, timestamp counter width
MAX_PEAK, 64, maximum samples spent in peak search before a forced emit (≥2)

Ports:
user_clk  in  1  sole clock (same user_clk as the threshold register)
user_rst  in  1  synchronous, active-high reset
threshold_in  in  32  packed config: [15:0] signed threshold, [27:16] dead time in samples, [30:28] reserved, [31] enable
in_valid  in  1  phase sample qualifier
in_data  in  DATA_W  signed phase sample
trig_valid  out  1  one-cycle event strobe
trig_peak  out  DATA_W  minimum sample of the pulse
trig_time  out  TS_W  timestamp of that minimum sample
busy  out  1  high in PEAK or DEAD

Behaviour:
- Reset: all outputs 0, state IDLE, timestamp 0, config copy 0 (disabled).
- Timestamp: free-running counter, increments every user_clk, wraps modulo 2^TS_W. It is not gated by in_valid. An event's time is the counter value in the cycle its min sample was presented.
- Config copy: threshold_in[31:0] is latched into an internal copy every cycle while in IDLE only. It is frozen during PEAK/DEAD, so register writes never corrupt a pulse in flight.
- Enable low (live threshold_in[31]=0): next state forced to IDLE from any state. An in-progress peak is discarded with no event. busy falls the following cycle.
- States, advancing only on in_valid=1 cycles:
  - IDLE: if enable and in_data < thr (strict, signed), go to PEAK. Load min=in_data, min_ts=timestamp, pk_cnt=1. Equal to thr does not trigger.
  - PEAK, if in_data < min: update min and min_ts, pk_cnt++.
  - PEAK, if in_data == min: keep the earlier min_ts, pk_cnt++.
  - PEAK, if in_data > min: emit.
  - PEAK, if pk_cnt reaches MAX_PEAK after an update: emit (forced). The forced emit includes the current sample in the min.
  - Emit: the next cycle drives trig_valid=1 for exactly one cycle, with trig_peak=min and trig_time=min_ts. Then load dcnt=dead time. Go to DEAD if dead time≠0, else to IDLE.
  - DEAD: decrement dcnt per valid sample. Samples are ignored. When dcnt reaches 1 and a valid sample arrives, go to IDLE. The first sample eligible to retrigger is the one after dead-time valid samples.
- Latency: trig_valid asserts exactly 1 cycle after the in_valid sample that ends the peak.
- trig_peak and trig_time hold their last values between strobes.
- in_valid low: state, min and counters hold. The timestamp still runs.
- A sample that ends a peak is never itself a retrigger candidate.
- Arithmetic: all comparisons signed DATA_W. pk_cnt is ceil(log2(MAX_PEAK+1)) bits. dcnt is 12 bits.
- Reset mid-operation: immediate return to reset values. Any pending strobe is dropped.

Optional Feature:
TRIG_EVENT_COUNT_EN:
- Defined: adds output port trig_count [31:0], a saturating count of emitted events (stops at 0xFFFFFFFF). Cleared by user_rst and on any cycle where enable=0.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Basic pulse: threshold_in=0x800A_FC18 (thr=-1000, dead=10, en). Feed valid samples 0, -500, -1200, -1500, -1400 at timestamps 5–9. Expect trig_valid at cycle 10 with trig_peak=-1500 (0xFA24) and trig_time=8.
- Dead time: same config, with 10 further samples of -2000 right after the emit. Expect no trigger. The 11th sample, -2000, must enter PEAK.
- Boundary and tie: feeding -1000 must not trigger. Sequence -1001, -1300, -1300, -1200 must give peak -1300 with trig_time equal to the first -1300 sample.
- Forced emit: MAX_PEAK=64, 70 strictly decreasing samples below thr. Expect one event 1 cycle after the 64th sample, with peak equal to that 64th sample's value.
- Disable and config freeze: write 0x0000_FC18 mid-PEAK. Expect no event, busy low next cycle. Separately, changing thr during DEAD must take effect only after returning to IDLE.
- Gaps and reset: in_valid toggled 1-0-0-1 inside a pulse gives the same event as contiguous input, with trig_time reflecting the real cycle. Asserting user_rst mid-PEAK gives all outputs 0 and no strobe.
